// File: rtl/mem_op_pkg.sv
// Shared definitions for the byte-serial memory unit: mem_op bit positions,
// FSM state encoding and small decode helpers.
package mem_op_pkg;

  localparam int MEM_LB  = 7;
  localparam int MEM_LH  = 6;
  localparam int MEM_LW  = 5;
  localparam int MEM_LBU = 4;
  localparam int MEM_LHU = 3;
  localparam int MEM_SB  = 2;
  localparam int MEM_SH  = 1;
  localparam int MEM_SW  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Multi-hot requests collapse to the highest set bit.
  function automatic logic [7:0] highest_op(input logic [7:0] op);
    logic [7:0] sel;
    sel = '0;
    for (int k = 0; k < 8; k++) begin
      if (op[k]) sel = 8'(1) << k;
    end
    return sel;
  endfunction

  function automatic logic [2:0] byte_count(input logic [7:0] op);
    if (op[MEM_LW] || op[MEM_SW]) return 3'd4;
    if (op[MEM_LH] || op[MEM_LHU] || op[MEM_SH]) return 3'd2;
    return 3'd1;
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op[MEM_SB] | op[MEM_SH] | op[MEM_SW];
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load formatter: picks and sign/zero-extends the captured
// little-endian bytes according to the latched one-hot load type.
module mem_load_ext
  import mem_op_pkg::*;
(
  input  logic [7:0]  i_op,
  input  logic [31:0] i_bytes,
  output logic [31:0] o_result
);

  always_comb begin
    o_result = i_bytes;
    if (i_op[MEM_LB])
      o_result = {{24{i_bytes[7]}}, i_bytes[7:0]};
    else if (i_op[MEM_LBU])
      o_result = {24'b0, i_bytes[7:0]};
    else if (i_op[MEM_LH])
      o_result = {{16{i_bytes[15]}}, i_bytes[15:0]};
    else if (i_op[MEM_LHU])
      o_result = {16'b0, i_bytes[15:0]};
  end

endmodule

// File: rtl/mem_serial_unit.sv
// Runs each load/store as a sequence of byte accesses on an 8-bit SRAM.
// An accepted request spends one cycle latching before its first SETUP.
module mem_serial_unit
  import mem_op_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [7:0]        mem_op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  state_t              r_state, w_next_state;
  logic                r_start;
  logic [7:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [2:0]          r_nbytes;
  logic [1:0]          r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_bytes;
  logic                r_busy, r_done, r_we_n, r_oe_n;
  logic [31:0]         r_rdata;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [7:0]          r_sram_wdata;

  logic                w_accept, w_last, w_store;
  logic [7:0]          w_op_sel;
  logic [1:0]          w_idx_next;
  logic [31:0]         w_bytes_cap, w_ext_result;

  assign w_op_sel = highest_op(mem_op);
  assign w_accept = (r_state == IDLE) && !r_start && req && (mem_op != 8'h00);
  assign w_store  = is_store(r_op);
  assign w_last   = (r_state == STROBE) && (r_cnt == CNT_W'(ACCESS_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE:   if (r_start) w_next_state = SETUP;
      SETUP:  w_next_state = STROBE;
      STROBE: begin
        if (w_last) begin
          if ({1'b0, r_idx} < (r_nbytes - 3'd1)) begin
            w_next_state = SETUP;
            w_idx_next   = r_idx + 2'd1;
          end else begin
            w_next_state = DONE;
          end
        end
      end
      DONE:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The final byte is merged combinationally so rdata can load on DONE entry.
  always_comb begin
    w_bytes_cap = r_bytes;
    w_bytes_cap[{r_idx, 3'b000} +: 8] = sram_rdata;
  end

  mem_load_ext u_load_ext (
    .i_op     (r_op),
    .i_bytes  (w_bytes_cap),
    .o_result (w_ext_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_start      <= 1'b0;
      r_op         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_nbytes     <= 3'd1;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_bytes      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_rdata      <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else begin
      r_start <= w_accept;
      r_cnt   <= (r_state == STROBE) ? r_cnt + CNT_W'(1) : '0;
      if (w_accept) begin
        r_op     <= w_op_sel;
        r_addr   <= addr[ADDR_W-1:0];
        r_wdata  <= wdata;
        r_nbytes <= byte_count(w_op_sel);
        r_idx    <= '0;
      end else begin
        r_idx    <= w_idx_next;
      end
      if (w_last && !w_store) begin
        r_bytes <= w_bytes_cap;
        if (w_next_state == DONE) r_rdata <= w_ext_result;
      end
      // Outputs are registered from the next state so each lines up with its state.
      case (w_next_state)
        SETUP: begin
          r_sram_addr  <= r_addr + ADDR_W'(w_idx_next);
          r_sram_wdata <= r_wdata[{w_idx_next, 3'b000} +: 8];
          r_we_n       <= 1'b1;
          r_oe_n       <= 1'b1;
          r_busy       <= 1'b1;
          r_done       <= 1'b0;
        end
        STROBE: begin
          r_we_n <= !w_store;
          r_oe_n <= w_store;
          r_busy <= 1'b1;
          r_done <= 1'b0;
        end
        DONE: begin
          r_we_n <= 1'b1;
          r_oe_n <= 1'b1;
          r_busy <= 1'b1;
          r_done <= 1'b1;
        end
        default: begin
          r_we_n <= 1'b1;
          r_oe_n <= 1'b1;
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign rdata      = r_rdata;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_we_n  = r_we_n;
  assign sram_oe_n  = r_oe_n;

endmodule
